score_keeper: RTL

- Downstream consumer of the ball/player motion block. Samples BallY and the jump counter every frame and runs the game-state FSM (IDLE/PLAY/OVER).
- Accumulates score from new platform bounces and tracks the session high score.
- Drives a sequential double-dabble BCD conversion of the score for the hex displays and the on-screen score renderer.

---
 rtl/game_pkg.sv | 18 +
 rtl/score_keeper_bcd_converter.sv | 53 +++++
 rtl/score_keeper.sv | 128 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: state encoding, screen limits and keycodes.
// The keycodes are also used by the ball/player motion block.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int SCREEN_Y_MAX = 479;
  localparam int SCORE_W      = 14;

  localparam logic [7:0] KEY_SPACE = 8'd44;
  localparam logic [7:0] KEY_A     = 8'd4;
  localparam logic [7:0] KEY_D     = 8'd7;

endpackage

// File: rtl/score_keeper_bcd_converter.sv
// Sequential double-dabble: converts one SCORE_W-bit value per run, one
// shift-add-3 step per clock; done/result are valid on the final step.
module bcd_converter
  import game_pkg::*;
(
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               busy,
  output logic               done,
  output logic [15:0]        result
);

  localparam int SREG_W = SCORE_W + 16;

  logic [SREG_W-1:0] sreg;
  logic [SREG_W-1:0] sreg_adj;
  logic [SREG_W-1:0] sreg_next;
  logic [3:0]        iter;

  always_comb begin
    sreg_adj = sreg;
    for (int d = 0; d < 4; d++) begin
      if (sreg[SCORE_W + 4*d +: 4] >= 4'd5)
        sreg_adj[SCORE_W + 4*d +: 4] = sreg[SCORE_W + 4*d +: 4] + 4'd3;
    end
    sreg_next = {sreg_adj[SREG_W-2:0], 1'b0};
  end

  // done is combinational so the caller can capture the final step directly
  assign done   = busy && (iter == 4'(SCORE_W - 1));
  assign result = sreg_next[SREG_W-1:SCORE_W];

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      sreg <= '0;
      iter <= '0;
      busy <= 1'b0;
    end else if (!busy) begin
      if (start) begin
        sreg <= {16'h0000, bin};
        iter <= '0;
        busy <= 1'b1;
      end
    end else begin
      sreg <= sreg_next;
      if (done) busy <= 1'b0;
      else      iter <= iter + 4'd1;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Game-state FSM, bounce-based scoring with saturation, session high score,
// and BCD display value derived from the score by a background converter.
module score_keeper
  import game_pkg::*;
#(
  parameter int         FLOOR_Y      = SCREEN_Y_MAX,
  parameter int         BALL_SIZE_Y  = 10,
  parameter int         FLOOR_FRAMES = 2,
  parameter logic [7:0] START_KEY    = KEY_SPACE,
  parameter int         MAX_SCORE    = 9999
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode,
  input  logic [10:0]        BallY,
  input  logic [15:0]        JumpCount,
  output logic [1:0]         game_state,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [15:0]        score_bcd,
  output logic               bcd_busy
);

  localparam logic [16:0]        MAX17      = 17'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] MAX_W      = SCORE_W'(MAX_SCORE);
  localparam logic [3:0]         FLOOR_LAST = 4'(FLOOR_FRAMES - 1);

  game_state_t        state, state_next;
  logic [SCORE_W-1:0] score_next, high_next, last_conv;
  logic [15:0]        last_count, last_next, delta;
  logic [16:0]        sum;
  logic [3:0]         floor_cnt, floor_next;
  logic [7:0]         prev_key;
  logic               start_pulse, contact;
  logic               conv_start, bcd_done;
  logic [15:0]        bcd_result;

  assign start_pulse = (keycode == START_KEY) && (prev_key != START_KEY);
  assign contact     = ({1'b0, BallY} + 12'(BALL_SIZE_Y)) >= 12'(FLOOR_Y);
  assign game_state  = state;
  assign game_over   = (state == OVER);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    score_next = score;
    high_next  = high_score;
    last_next  = last_count;
    floor_next = floor_cnt;
    delta      = JumpCount - last_count;
    sum        = {3'b000, score} + {1'b0, delta};
    unique case (state)
      IDLE: begin
        score_next = '0;
        if (start_pulse) begin
          state_next = PLAY;
          last_next  = JumpCount;
          floor_next = '0;
        end
      end
      PLAY: begin
        // a falling count means a floor reset or wrap: no credit
        if (JumpCount > last_count)
          score_next = (sum > MAX17) ? MAX_W : sum[SCORE_W-1:0];
        last_next = JumpCount;
        if (contact) begin
          floor_next = floor_cnt + 4'd1;
          if (floor_cnt == FLOOR_LAST) state_next = OVER;
        end else begin
          floor_next = '0;
        end
      end
      OVER: begin
        if (score > high_score) high_next = score;
        if (start_pulse) begin
          state_next = IDLE;
          score_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      score      <= '0;
      high_score <= '0;
      last_count <= '0;
      floor_cnt  <= '0;
      prev_key   <= '0;
    end else begin
      score      <= score_next;
      high_score <= high_next;
      last_count <= last_next;
      floor_cnt  <= floor_next;
      prev_key   <= keycode;
    end
  end

  // score changes during a run are picked up by this compare once idle again
  assign conv_start = !bcd_busy && (score != last_conv);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      last_conv <= '0;
      score_bcd <= '0;
    end else begin
      if (conv_start) last_conv <= score;
      if (bcd_done)   score_bcd <= bcd_result;
    end
  end

  bcd_converter u_bcd (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .start     (conv_start),
    .bin       (score),
    .busy      (bcd_busy),
    .done      (bcd_done),
    .result    (bcd_result)
  );

endmodule
